grn_attractor_ctrl: RTL and testbench

GRN_ATTRACTOR_CTRL -- requirements
Module: grn_attractor_ctrl

---
 rtl/grn_pkg.sv | 16 +
 rtl/grn_attractor_ctrl_if.sv | 24 ++
 rtl/grn_vec_cmp.sv | 12 +
 rtl/grn_attractor_ctrl.sv | 153 +++++++++++++++
 tb/tb_grn_attractor_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grn_pkg.sv
// Shared types and default sizes for the gene-regulatory-network attractor controller.
package grn_pkg;

  localparam int N_NODES_DEF = 188;
  localparam int CNT_W_DEF   = 24;
  localparam int IDX_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_PERIOD = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

endpackage

// File: rtl/grn_attractor_ctrl_if.sv
// Result handshake bundle: one attractor record (meet step, period, timeout) per initial state.
interface grn_attractor_ctrl_if import grn_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) ();

  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_idx;
  logic [CNT_W-1:0] res_meet;
  logic [CNT_W-1:0] res_period;
  logic             res_timeout;

  modport master (
    output res_valid, res_idx, res_meet, res_period, res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_idx, res_meet, res_period, res_timeout,
    output res_ready
  );

endinterface

// File: rtl/grn_vec_cmp.sv
// Purely combinational wide equality compare of the slow and fast node state vectors.
module grn_vec_cmp #(
  parameter int W = 188
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Sweeps initial states through an external node array and finds each attractor with
// tortoise/hare stepping (s0 half rate, s1 full rate), then measures the cycle period.
module grn_attractor_ctrl import grn_pkg::*; #(
  parameter int N_NODES = N_NODES_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] seed,
  input  logic [IDX_W-1:0]   num_inits,
  input  logic [CNT_W-1:0]   max_steps,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  grn_attractor_ctrl_if.master res,
  output logic               busy,
  output logic               done
);

  localparam int EW = (N_NODES < IDX_W) ? N_NODES : IDX_W;

  state_t             state;
  logic [N_NODES-1:0] seed_r;
  logic [IDX_W-1:0]   num_r;
  logic [CNT_W-1:0]   max_r;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   k;
  logic [CNT_W-1:0]   p;
  logic [CNT_W-1:0]   meet_r;
  logic [CNT_W-1:0]   period_r;
  logic               timeout_r;
  logic [N_NODES-1:0] idx_ext;
  logic               vec_eq;
  logic               meet_hit;
  logic               search_to;
  logic               period_hit;
  logic               period_to;

  grn_vec_cmp #(.W(N_NODES)) u_cmp (
    .a  (s0_vec),
    .b  (s1_vec),
    .eq (vec_eq)
  );

  always_comb begin
    idx_ext = '0;
    for (int i = 0; i < EW; i++) idx_ext[i] = idx[i];
  end

  assign init_state = seed_r ^ idx_ext;

  // Meet takes priority over the step limit when both land on the same cycle.
  assign meet_hit   = (state == ST_SEARCH) && !k[0] && (k[CNT_W-1:1] != '0) && vec_eq;
  assign search_to  = (state == ST_SEARCH) && !meet_hit && (k == max_r);
  assign period_hit = (state == ST_PERIOD) && (p != '0) && vec_eq;
  assign period_to  = (state == ST_PERIOD) && !period_hit && (p == max_r);

  assign reset_nos = (state == ST_LOAD);
  assign start_s0  = (state == ST_SEARCH) && !meet_hit && !search_to;
  assign start_s1  = start_s0 || ((state == ST_PERIOD) && !period_hit && !period_to);
  assign busy      = (state != ST_IDLE);

  assign res.res_valid   = (state == ST_REPORT);
  assign res.res_idx     = idx;
  assign res.res_meet    = meet_r;
  assign res.res_period  = period_r;
  assign res.res_timeout = timeout_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      seed_r    <= '0;
      num_r     <= '0;
      max_r     <= '0;
      idx       <= '0;
      k         <= '0;
      p         <= '0;
      meet_r    <= '0;
      period_r  <= '0;
      timeout_r <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_inits == '0) begin
              done <= 1'b1;
            end else begin
              seed_r <= seed;
              num_r  <= num_inits;
              max_r  <= max_steps;
              idx    <= '0;
              state  <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          k         <= '0;
          p         <= '0;
          meet_r    <= '0;
          period_r  <= '0;
          timeout_r <= 1'b0;
          state     <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (meet_hit) begin
            meet_r <= k;
            p      <= '0;
            state  <= ST_PERIOD;
          end else if (search_to) begin
            timeout_r <= 1'b1;
            meet_r    <= k;
            period_r  <= '0;
            state     <= ST_REPORT;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_PERIOD: begin
          if (period_hit) begin
            period_r <= p;
            state    <= ST_REPORT;
          end else if (period_to) begin
            timeout_r <= 1'b1;
            period_r  <= '0;
            state     <= ST_REPORT;
          end else begin
            p <= p + 1'b1;
          end
        end
        ST_REPORT: begin
          if (res.res_ready) begin
            idx <= idx + 1'b1;
            if ((idx + 1'b1) == num_r) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: a 4-node behavioural network with selectable next-state table
// and an abstract attractor model computed directly from iterating the network map.
module tb_grn_attractor_ctrl;

  localparam int NN = 4;
  localparam int CW = 8;
  localparam int IW = 16;

  typedef struct packed {
    int   idx;
    int   meet;
    int   period;
    logic to;
  } result_t;

  typedef struct {
    int         net;
    logic [3:0] sd;
    int         mx;
    int         meet;
    int         period;
    logic       to;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NN-1:0] seed;
  logic [IW-1:0] num_inits;
  logic [CW-1:0] max_steps;
  logic [NN-1:0] s0_vec;
  logic [NN-1:0] s1_vec;
  logic          reset_nos;
  logic          start_s0;
  logic          start_s1;
  logic [NN-1:0] init_state;
  logic          busy;
  logic          done;

  grn_attractor_ctrl_if #(.CNT_W(CW), .IDX_W(IW)) res_if ();

  grn_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .num_inits  (num_inits),
    .max_steps  (max_steps),
    .s0_vec     (s0_vec),
    .s1_vec     (s1_vec),
    .reset_nos  (reset_nos),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .init_state (init_state),
    .res        (res_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      failures = 0;
  result_t got[$];
  int      done_seen;

  // Network map: row lut[state] holds every node's next value for that global state.
  logic [3:0] lut [16];

  function automatic logic [3:0] net_next(input logic [3:0] st);
    logic [3:0] nx;
    logic [3:0] row;
    row = lut[st];
    for (int i = 0; i < NN; i++) nx[i] = row[i];
    return nx;
  endfunction

  // Behavioural node array: s1 steps on every start_s1, s0 steps on every second start_s0.
  logic [3:0] nd_s0 = '0;
  logic [3:0] nd_s1 = '0;
  logic       nd_pass = 1'b0;

  always @(posedge clk) begin
    if (reset_nos) begin
      nd_s0   <= init_state;
      nd_s1   <= init_state;
      nd_pass <= 1'b0;
    end else begin
      if (start_s1) nd_s1 <= net_next(nd_s1);
      if (start_s0) begin
        nd_pass <= ~nd_pass;
        if (nd_pass) nd_s0 <= net_next(nd_s0);
      end
    end
  end

  assign s0_vec = nd_s0;
  assign s1_vec = nd_s1;

  task automatic set_net(input int kind);
    for (int s = 0; s < 16; s++) begin
      logic [3:0] v;
      v = s[3:0];
      case (kind)
        0:       lut[s] = v;
        1:       lut[s] = {v[2:0], v[3]};
        default: lut[s] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  function automatic logic [3:0] iter(input logic [3:0] x, input int n);
    logic [3:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = lut[y];
    return y;
  endfunction

  // Attractor reference: smallest even k>=2 with f^k(x)==f^(k/2)(x), then cycle length at f^k(x).
  function automatic result_t model(input logic [3:0] x, input int idx, input int mx);
    result_t r;
    r.idx = idx; r.meet = mx; r.period = 0; r.to = 1'b1;
    for (int k = 2; k <= mx; k += 2) begin
      if (iter(x, k) == iter(x, k / 2)) begin
        r.meet = k;
        for (int p = 1; p <= mx; p++) begin
          if (iter(iter(x, k), p) == iter(x, k)) begin
            r.period = p;
            r.to = 1'b0;
            return r;
          end
        end
        return r;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic result_t capture();
    result_t r;
    r.idx    = int'(res_if.res_idx);
    r.meet   = int'(res_if.res_meet);
    r.period = int'(res_if.res_period);
    r.to     = res_if.res_timeout;
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_reset_nos"}, reset_nos, 0);
    chk({tag, "_start_s0"}, start_s0, 0);
    chk({tag, "_start_s1"}, start_s1, 0);
    chk({tag, "_res_valid"}, res_if.res_valid, 0);
    chk({tag, "_res_timeout"}, res_if.res_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res_idx"}, res_if.res_idx, 0);
    chk({tag, "_res_meet"}, res_if.res_meet, 0);
    chk({tag, "_res_period"}, res_if.res_period, 0);
    chk({tag, "_init_state"}, init_state, 0);
  endtask

  // Runs one sweep, collecting every handshaken record into got[] and counting done pulses.
  task automatic do_sweep(input logic [3:0] sd, input int n, input int mx,
                          input int stall, input bit rnd, input bit poke);
    result_t cur;
    bit      have;
    bit      fin;
    int      waitc;
    int      cyc;
    int      unstable;
    got.delete();
    done_seen = 0; have = 0; fin = 0; waitc = 0; cyc = 0; unstable = 0;
    @(negedge clk);
    seed = sd; num_inits = n[IW-1:0]; max_steps = mx[CW-1:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin) begin
      if (poke && cyc == 3) begin
        start = 1'b1; seed = ~sd; num_inits = 16'd7; max_steps = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_seen++;
        fin = 1;
      end
      if (res_if.res_valid === 1'b1) begin
        if (!have) begin
          cur = capture(); have = 1; waitc = 0;
        end else if (capture() != cur) begin
          unstable++;
        end
        res_if.res_ready = rnd ? ($urandom_range(0, 2) == 0) : (waitc >= stall);
        waitc++;
        if (res_if.res_ready) begin
          got.push_back(cur);
          have = 0;
        end
      end else begin
        res_if.res_ready = 1'b0;
      end
      if (!fin) begin
        cyc++;
        if (cyc > 4000) begin
          chk("sweep_cycle_budget", cyc, 0);
          fin = 1;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    res_if.res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("payload_stable", unstable, 0);
  endtask

  task automatic check_model(input string tag, input logic [3:0] sd, input int n, input int mx);
    chk({tag, "_count"}, got.size(), n);
    chk({tag, "_done_pulses"}, done_seen, 1);
    for (int i = 0; i < n && i < got.size(); i++) begin
      result_t e;
      e = model(sd ^ i[3:0], i, mx);
      chk($sformatf("%s_idx%0d", tag, i), got[i].idx, e.idx);
      chk($sformatf("%s_meet%0d", tag, i), got[i].meet, e.meet);
      chk($sformatf("%s_period%0d", tag, i), got[i].period, e.period);
      chk($sformatf("%s_timeout%0d", tag, i), got[i].to, e.to);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    int   cyc;
    int   dcount;
    vecs[0] = '{0, 4'b0000, 20, 2, 1, 1'b0};
    vecs[1] = '{1, 4'b0001, 20, 8, 4, 1'b0};
    vecs[2] = '{1, 4'b0001, 1, 1, 0, 1'b1};
    vecs[3] = '{1, 4'b0001, 0, 0, 0, 1'b1};
    vecs[4] = '{1, 4'b0101, 20, 4, 2, 1'b0};
    vecs[5] = '{1, 4'b1111, 20, 2, 1, 1'b0};
    vecs[6] = '{1, 4'b0001, 6, 6, 0, 1'b1};
    vecs[7] = '{1, 4'b0001, 8, 8, 4, 1'b0};
    vecs[8] = '{0, 4'b1010, 2, 2, 1, 1'b0};

    set_net(0);
    rst = 1'b1; start = 1'b0; seed = '0; num_inits = '0; max_steps = '0;
    res_if.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    foreach (vecs[v]) begin
      set_net(vecs[v].net);
      do_sweep(vecs[v].sd, 1, vecs[v].mx, 0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_count", v), got.size(), 1);
      chk($sformatf("vec%0d_done_pulses", v), done_seen, 1);
      if (got.size() > 0) begin
        chk($sformatf("vec%0d_idx", v), got[0].idx, 0);
        chk($sformatf("vec%0d_meet", v), got[0].meet, vecs[v].meet);
        chk($sformatf("vec%0d_period", v), got[0].period, vecs[v].period);
        chk($sformatf("vec%0d_timeout", v), got[0].to, vecs[v].to);
      end
    end

    // Zero initial states: done pulse without any result or busy period.
    do_sweep(4'b0110, 0, 20, 0, 1'b0, 1'b0);
    chk("zero_inits_count", got.size(), 0);
    chk("zero_inits_done", done_seen, 1);
    chk("zero_inits_busy", busy, 0);

    // Three states, 10-cycle stalls, with a start pulse injected mid-sweep.
    set_net(1);
    do_sweep(4'b0001, 3, 20, 10, 1'b0, 1'b1);
    check_model("stall3", 4'b0001, 3, 20);

    // Reset during PERIOD of idx 1 (together with start), then a clean full sweep.
    set_net(1);
    @(negedge clk);
    seed = 4'b0000; num_inits = 16'd3; max_steps = 8'd20; start = 1'b1;
    res_if.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(res_if.res_idx == 16'd1 && start_s1 && !start_s0) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_period", (cyc < 500), 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0; start = 1'b0; res_if.res_ready = 1'b0;
    dcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    chk("midrst_idle", busy, 0);
    do_sweep(4'b0000, 2, 20, 0, 1'b0, 1'b0);
    check_model("after_rst", 4'b0000, 2, 20);

    // Random networks, seeds, limits and backpressure.
    for (int r = 0; r < 8; r++) begin
      logic [3:0] sd;
      int         n;
      int         mx;
      set_net(2);
      sd = 4'($urandom_range(0, 15));
      n  = $urandom_range(1, 4);
      mx = $urandom_range(0, 40);
      do_sweep(sd, n, mx, 0, 1'b1, 1'b0);
      check_model($sformatf("rand%0d", r), sd, n, mx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
